qkt_matmul_sequencer: RTL and testbench

- Sequences the Qn x KnT systolic-array wrapper inside one self-attention head.
- Generates that wrapper's en / rst_n / reset_acc / out_valid controls, so the head no longer takes them as top-level pins.
- Fetches input blocks from the bridge buffer over a req/valid handshake and accumulates INNER_BLOCKS partial products per output tile.
- Hands each finished tile downstream over a valid/ready handshake; repeats for OUT_TILES tiles per job.

---
 rtl/qkt_matmul_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_qkt_matmul_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qkt_matmul_sequencer.sv
// Control sequencer for the Qn x KnT systolic-array wrapper: fetch, accumulate, and hand off output tiles.
// Optional compute watchdog enabled by defining QKT_MATMUL_SEQUENCER_TIMEOUT_EN.
module qkt_matmul_sequencer #(
    parameter int INNER_BLOCKS   = 4,
    parameter int OUT_TILES      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic                           in_req,
    input  logic                           in_valid,
    input  logic                           sys_finish,
    input  logic                           acc_done,
    output logic                           en_Qn_KnT,
    output logic                           rst_n_Qn_KnT,
    output logic                           reset_acc_Qn_KnT,
    output logic                           out_valid_Qn_KnT,
    input  logic                           out_ready,
    output logic [$clog2(INNER_BLOCKS):0]  inner_idx,
    output logic [$clog2(OUT_TILES):0]     tile_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int IW = $clog2(INNER_BLOCKS) + 1;
    localparam int TW = $clog2(OUT_TILES) + 1;
    localparam logic [IW-1:0] INNER_LAST = IW'(INNER_BLOCKS - 1);
    localparam logic [TW-1:0] TILE_LAST  = TW'(OUT_TILES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_COMPUTE, S_RESTART, S_WAIT_ACC, S_OUTPUT, S_DONE
    } state_e;

    typedef struct packed {
        logic in_req;
        logic en;
        logic rst_n_arr;
        logic reset_acc;
        logic out_valid;
        logic busy;
        logic done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Outputs are decoded from the next state and flopped, so each one equals a decode of the current state.
    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c      = CTRL_IDLE;
        c.busy = (s != S_IDLE);
        case (s)
            S_CLEAR:   begin c.rst_n_arr = 1'b0; c.reset_acc = 1'b1; end
            S_FETCH:   c.in_req    = 1'b1;
            S_COMPUTE: c.en        = 1'b1;
            S_RESTART: c.rst_n_arr = 1'b0;
            S_OUTPUT:  c.out_valid = 1'b1;
            S_DONE:    c.done      = 1'b1;
            default:   ;
        endcase
        return c;
    endfunction

    state_e        state_q, state_d;
    logic [IW-1:0] inner_q, inner_d;
    logic [TW-1:0] tile_q, tile_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          timeout;

`ifdef QKT_MATMUL_SEQUENCER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Held at zero outside COMPUTE, so every entry into COMPUTE starts from a clean count.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (state_q == S_COMPUTE && cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        if (state_q == S_IDLE && start && !abort)      err_d = 1'b0;
        if (timeout && !abort)                         err_d = 1'b1;
    end

    assign timeout = (state_q == S_COMPUTE) && (cnt_q == CNT_LAST) && !sys_finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        inner_d = inner_q;
        tile_d  = tile_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CLEAR;
                inner_d = '0;
                tile_d  = '0;
            end
            S_CLEAR:   state_d = S_FETCH;
            S_FETCH:   if (ctrl_q.in_req && in_valid) state_d = S_COMPUTE;
            S_COMPUTE: begin
                if (sys_finish) begin
                    if (inner_q != INNER_LAST) begin
                        state_d = S_RESTART;
                        inner_d = inner_q + 1'b1;
                    end else begin
                        state_d = S_WAIT_ACC;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    inner_d = '0;
                    tile_d  = '0;
                end
            end
            S_RESTART:  state_d = S_FETCH;
            S_WAIT_ACC: if (acc_done) state_d = S_OUTPUT;
            S_OUTPUT: if (ctrl_q.out_valid && out_ready) begin
                if (tile_q != TILE_LAST) begin
                    state_d = S_CLEAR;
                    tile_d  = tile_q + 1'b1;
                    inner_d = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                inner_d = '0;
                tile_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every event above, including a final output handshake.
        if (abort) begin
            state_d = S_IDLE;
            inner_d = '0;
            tile_d  = '0;
        end
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            inner_q <= '0;
            tile_q  <= '0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
            state_q <= state_d;
            inner_q <= inner_d;
            tile_q  <= tile_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign in_req           = ctrl_q.in_req;
    assign en_Qn_KnT        = ctrl_q.en;
    assign rst_n_Qn_KnT     = ctrl_q.rst_n_arr;
    assign reset_acc_Qn_KnT = ctrl_q.reset_acc;
    assign out_valid_Qn_KnT = ctrl_q.out_valid;
    assign busy             = ctrl_q.busy;
    assign done             = ctrl_q.done;
    assign inner_idx        = inner_q;
    assign tile_idx         = tile_q;

endmodule

// File: tb/tb_qkt_matmul_sequencer.sv
// Self-checking bench for qkt_matmul_sequencer: three instances (4x2, 1x1, 1x1 with short watchdog) driven by directed steps.
module tb_qkt_matmul_sequencer;
    logic clk;
    logic rst_n;

    // Instance A: INNER_BLOCKS=4, OUT_TILES=2
    logic       a_start, a_abort, a_in_valid, a_sys_finish, a_acc_done, a_out_ready;
    logic       a_in_req, a_en, a_rstq, a_racc, a_ov, a_busy, a_done, a_err;
    logic [2:0] a_inner;
    logic [1:0] a_tile;

    // Instance B: INNER_BLOCKS=1, OUT_TILES=1
    logic       b_start, b_abort, b_in_valid, b_sys_finish, b_acc_done, b_out_ready;
    logic       b_in_req, b_en, b_rstq, b_racc, b_ov, b_busy, b_done, b_err;
    logic [0:0] b_inner;
    logic [0:0] b_tile;

    // Instance C: INNER_BLOCKS=1, OUT_TILES=1, TIMEOUT_CYCLES=16
    logic       c_start, c_abort, c_in_valid, c_sys_finish, c_acc_done, c_out_ready;
    logic       c_in_req, c_en, c_rstq, c_racc, c_ov, c_busy, c_done, c_err;
    logic [0:0] c_inner;
    logic [0:0] c_tile;

    qkt_matmul_sequencer #(.INNER_BLOCKS(4), .OUT_TILES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .in_req(a_in_req), .in_valid(a_in_valid), .sys_finish(a_sys_finish), .acc_done(a_acc_done),
        .en_Qn_KnT(a_en), .rst_n_Qn_KnT(a_rstq), .reset_acc_Qn_KnT(a_racc),
        .out_valid_Qn_KnT(a_ov), .out_ready(a_out_ready),
        .inner_idx(a_inner), .tile_idx(a_tile), .busy(a_busy), .done(a_done), .err(a_err)
    );

    qkt_matmul_sequencer #(.INNER_BLOCKS(1), .OUT_TILES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .in_req(b_in_req), .in_valid(b_in_valid), .sys_finish(b_sys_finish), .acc_done(b_acc_done),
        .en_Qn_KnT(b_en), .rst_n_Qn_KnT(b_rstq), .reset_acc_Qn_KnT(b_racc),
        .out_valid_Qn_KnT(b_ov), .out_ready(b_out_ready),
        .inner_idx(b_inner), .tile_idx(b_tile), .busy(b_busy), .done(b_done), .err(b_err)
    );

    qkt_matmul_sequencer #(.INNER_BLOCKS(1), .OUT_TILES(1), .TIMEOUT_CYCLES(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .in_req(c_in_req), .in_valid(c_in_valid), .sys_finish(c_sys_finish), .acc_done(c_acc_done),
        .en_Qn_KnT(c_en), .rst_n_Qn_KnT(c_rstq), .reset_acc_Qn_KnT(c_racc),
        .out_valid_Qn_KnT(c_ov), .out_ready(c_out_ready),
        .inner_idx(c_inner), .tile_idx(c_tile), .busy(c_busy), .done(c_done), .err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {ST_IDLE, ST_CLEAR, ST_FETCH, ST_COMPUTE, ST_RESTART, ST_WAIT, ST_OUTPUT, ST_DONE} st_e;

    int errors = 0;
    int checks = 0;

    // Scoreboards hold expected {tile_idx, inner_idx} per fetch and per output handshake.
    logic [4:0] a_exp_fetch[$];
    logic [4:0] a_exp_out[$];
    logic [1:0] b_exp_fetch[$];
    logic [1:0] b_exp_out[$];

    int a_fetch_hs = 0, a_clear_n = 0, a_restart_n = 0, a_out_hs = 0, a_done_n = 0;
    int b_restart_n = 0, b_done_n = 0;
    int cycles;
    int base_done;

    function automatic st_e classify(input logic busy, input logic in_req, input logic en,
                                     input logic rstq, input logic racc, input logic ov,
                                     input logic done);
        if (!busy)  return ST_IDLE;
        if (done)   return ST_DONE;
        if (!rstq)  return racc ? ST_CLEAR : ST_RESTART;
        if (in_req) return ST_FETCH;
        if (en)     return ST_COMPUTE;
        if (ov)     return ST_OUTPUT;
        return ST_WAIT;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge with inputs already set for the coming rising edge: tallies the
    // handshakes that edge will complete, then advances to the next falling edge.
    task automatic tick();
        logic [4:0] ea;
        logic [1:0] eb;
        if (a_in_req && a_in_valid && !a_abort) begin
            a_fetch_hs++;
            check("a_fetch_sb_nonempty", 32'(a_exp_fetch.size() != 0), 1);
            if (a_exp_fetch.size() != 0) begin
                ea = a_exp_fetch.pop_front();
                check("a_fetch_idx", {27'd0, a_tile, a_inner}, {27'd0, ea});
            end
        end
        if (a_ov && a_out_ready && !a_abort) begin
            a_out_hs++;
            check("a_out_sb_nonempty", 32'(a_exp_out.size() != 0), 1);
            if (a_exp_out.size() != 0) begin
                ea = a_exp_out.pop_front();
                check("a_out_idx", {27'd0, a_tile, a_inner}, {27'd0, ea});
            end
        end
        if (!a_rstq && a_racc)  a_clear_n++;
        if (!a_rstq && !a_racc) a_restart_n++;
        if (a_done)             a_done_n++;
        if (b_in_req && b_in_valid && !b_abort) begin
            check("b_fetch_sb_nonempty", 32'(b_exp_fetch.size() != 0), 1);
            if (b_exp_fetch.size() != 0) begin
                eb = b_exp_fetch.pop_front();
                check("b_fetch_idx", {30'd0, b_tile, b_inner}, {30'd0, eb});
            end
        end
        if (b_ov && b_out_ready && !b_abort) begin
            check("b_out_sb_nonempty", 32'(b_exp_out.size() != 0), 1);
            if (b_exp_out.size() != 0) begin
                eb = b_exp_out.pop_front();
                check("b_out_idx", {30'd0, b_tile, b_inner}, {30'd0, eb});
            end
        end
        if (!b_rstq && !b_racc) b_restart_n++;
        if (b_done)             b_done_n++;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        st_e b_seq[6];
        b_seq = '{ST_CLEAR, ST_FETCH, ST_COMPUTE, ST_WAIT, ST_OUTPUT, ST_DONE};

        rst_n = 1'b0;
        {a_start, a_abort, a_in_valid, a_sys_finish, a_acc_done, a_out_ready} = '0;
        {b_start, b_abort, b_in_valid, b_sys_finish, b_acc_done, b_out_ready} = '0;
        {c_start, c_abort, c_in_valid, c_sys_finish, c_acc_done, c_out_ready} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_busy",    a_busy, 0);
        check("rst_in_req",  a_in_req, 0);
        check("rst_en",      a_en, 0);
        check("rst_rstq",    a_rstq, 1);
        check("rst_racc",    a_racc, 0);
        check("rst_ov",      a_ov, 0);
        check("rst_done",    a_done, 0);
        check("rst_err",     a_err, 0);
        check("rst_inner",   32'(a_inner), 0);
        check("rst_tile",    32'(a_tile), 0);
        check("rst_c_err",   c_err, 0);

        // Zero-wait full job on A: 4 inner blocks x 2 tiles
        {a_in_valid, a_sys_finish, a_acc_done, a_out_ready} = 4'b1111;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 4; i++) a_exp_fetch.push_back({t[1:0], i[2:0]});
            a_exp_out.push_back({t[1:0], 3'd3});
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        cycles = 1;
        while (cycles < 60 && !a_done) begin
            tick();
            cycles++;
        end
        check("t1_done_seen", a_done, 1);
        check("t1_cycles_to_done", 32'(cycles), 29);
        tick();
        check("t1_busy_after_done", a_busy, 0);
        check("t1_done_one_cycle", a_done, 0);
        check("t1_inner_cleared", 32'(a_inner), 0);
        check("t1_tile_cleared", 32'(a_tile), 0);
        check("t1_fetch_hs", 32'(a_fetch_hs), 8);
        check("t1_clear_pulses", 32'(a_clear_n), 2);
        check("t1_restart_pulses", 32'(a_restart_n), 6);
        check("t1_out_hs", 32'(a_out_hs), 2);
        check("t1_done_pulses", 32'(a_done_n), 1);
        check("t1_fetch_sb_empty", 32'(a_exp_fetch.size()), 0);
        check("t1_out_sb_empty", 32'(a_exp_out.size()), 0);

        // Delayed sys_finish, output backpressure, then abort on the final handshake
        base_done = a_done_n;
        {a_in_valid, a_sys_finish, a_acc_done, a_out_ready} = 4'b1010;
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 4; i++) a_exp_fetch.push_back({t[1:0], i[2:0]});
        a_exp_out.push_back({2'd0, 3'd3});
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 10 && !a_en; k++) tick();
        check("t3_en_reached", a_en, 1);
        for (int j = 0; j < 7; j++) begin
            check("t3_en_held", a_en, 1);
            check("t3_inner_held", 32'(a_inner), 0);
            tick();
        end
        a_sys_finish = 1'b1;
        check("t3_en_finish_cycle", a_en, 1);
        tick();
        check("t3_en_dropped", a_en, 0);
        check("t3_inner_incr", 32'(a_inner), 1);
        for (int k = 0; k < 40 && !a_ov; k++) tick();
        check("t2_ov_reached", a_ov, 1);
        a_start = 1'b1;
        for (int j = 0; j < 10; j++) begin
            check("t2_ov_held", a_ov, 1);
            check("t2_tile_held", 32'(a_tile), 0);
            tick();
        end
        a_start = 1'b0;
        a_out_ready = 1'b1;
        check("t2_ov_cycle11", a_ov, 1);
        tick();
        a_out_ready = 1'b0;
        check("t2_state_after_hs", 32'(classify(a_busy, a_in_req, a_en, a_rstq, a_racc, a_ov, a_done)), 32'(ST_CLEAR));
        check("t2_tile_incr", 32'(a_tile), 1);
        check("t2_inner_reset", 32'(a_inner), 0);
        for (int k = 0; k < 40 && !a_ov; k++) tick();
        check("t5_ov_reached", a_ov, 1);
        check("t5_tile_last", 32'(a_tile), 1);
        a_out_ready = 1'b1;
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        a_out_ready = 1'b0;
        check("t5_abort_idle", a_busy, 0);
        check("t5_abort_ov", a_ov, 0);
        check("t5_abort_done", a_done, 0);
        check("t5_abort_rstq", a_rstq, 1);
        check("t5_abort_tile", 32'(a_tile), 0);
        check("t5_abort_inner", 32'(a_inner), 0);
        tick();
        check("t5_no_late_done", a_done, 0);
        check("t5_done_count", 32'(a_done_n - base_done), 0);
        check("t5_fetch_sb_empty", 32'(a_exp_fetch.size()), 0);
        check("t5_out_sb_empty", 32'(a_exp_out.size()), 0);

        // Async reset in the middle of COMPUTE
        {a_in_valid, a_sys_finish, a_acc_done, a_out_ready} = 4'b1000;
        a_exp_fetch.push_back({2'd0, 3'd0});
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 10 && !a_en; k++) tick();
        check("t5r_en_reached", a_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5r_en", a_en, 0);
        check("t5r_busy", a_busy, 0);
        check("t5r_rstq", a_rstq, 1);
        check("t5r_in_req", a_in_req, 0);
        check("t5r_done", a_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5r_still_idle", a_busy, 0);
        check("t5r_done_count", 32'(a_done_n - base_done), 0);
        check("t5r_fetch_sb_empty", 32'(a_exp_fetch.size()), 0);

        // Instance B: single inner block, single tile; start during DONE is ignored
        {b_in_valid, b_sys_finish, b_acc_done, b_out_ready} = 4'b1111;
        b_exp_fetch.push_back(2'b00);
        b_exp_out.push_back(2'b00);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t4_state_seq", 32'(classify(b_busy, b_in_req, b_en, b_rstq, b_racc, b_ov, b_done)), 32'(b_seq[i]));
            if (i == 5) b_start = 1'b1;
            tick();
        end
        b_start = 1'b0;
        check("t4_idle_after_done", b_busy, 0);
        tick();
        check("t4_start_in_done_ignored", b_busy, 0);
        check("t4_no_restart", 32'(b_restart_n), 0);
        check("t4_done_once", 32'(b_done_n), 1);
        check("t4_out_sb_empty", 32'(b_exp_out.size()), 0);

`ifdef QKT_MATMUL_SEQUENCER_TIMEOUT_EN
        // Instance C: sys_finish never arrives; watchdog fires after 16 COMPUTE cycles
        c_in_valid = 1'b1;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 10 && !c_en; k++) tick();
        for (int j = 0; j < 16; j++) begin
            check("t6_en_held", c_en, 1);
            check("t6_err_low", c_err, 0);
            tick();
        end
        check("t6_err_set", c_err, 1);
        check("t6_idle", c_busy, 0);
        check("t6_no_done", c_done, 0);
        tick();
        check("t6_err_sticky", c_err, 1);
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        check("t6_err_cleared", c_err, 0);
        check("t6_restarted", c_busy, 1);
        c_abort = 1'b1;
        tick();
        c_abort = 1'b0;
        check("t6_abort_idle", c_busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
